// File: rtl/windower_kernel_if.sv
// Stream bundle for windower_kernel: input beats in, sliding-window vectors out.
// The kernel takes the slave view; the producer/consumer side takes master.
interface windower_kernel_if #(
  parameter int NO_CH      = 2,
  parameter int THROUGHPUT = 1,
  parameter int KERNEL     = 3
);
  logic                                     in_vld;
  logic                                     in_rdy;
  logic [THROUGHPUT-1:0][NO_CH-1:0]         data_in;
  logic                                     out_vld;
  logic                                     out_rdy;
  logic [THROUGHPUT+KERNEL-2:0][NO_CH-1:0]  data_out;
  logic                                     out_first;
  logic                                     out_last;

  modport slave (
    input  in_vld, data_in, out_rdy,
    output in_rdy, out_vld, data_out, out_first, out_last
  );

  modport master (
    output in_vld, data_in, out_rdy,
    input  in_rdy, out_vld, data_out, out_first, out_last
  );
endinterface

// File: rtl/windower_kernel.sv
// Streaming 1-D window generator: each output beat carries THROUGHPUT+KERNEL-1
// samples centred on one input beat, with zero or edge-replicate boundary padding.
module windower_kernel #(
  parameter int NO_CH          = 2,
  parameter int LOG2_IMG_BEATS = 10,
  parameter int THROUGHPUT     = 1,
  parameter int KERNEL         = 3,
  parameter int PAD_MODE       = 0
) (
  input  logic              clk,
  input  logic              rst,
  windower_kernel_if.slave  bus
);
  localparam int T = THROUGHPUT;
  localparam int H = (KERNEL - 1) / 2;
  localparam int W = THROUGHPUT + KERNEL - 1;
  localparam bit SHORT_IMG = (LOG2_IMG_BEATS == 1);
  localparam logic [LOG2_IMG_BEATS-1:0] CNTR_LAST = '1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  typedef logic [NO_CH-1:0] sample_t;

  state_t                    state_q, state_d;
  logic [LOG2_IMG_BEATS-1:0] cntr_q, cntr_d;
  logic                      out_vld_q, out_vld_d;
  logic                      out_first_q, out_first_d;
  logic                      out_last_q, out_last_d;
  sample_t [T-1:0]           prev_q, prev_d;
  sample_t [T-1:0]           cur_q, cur_d;
  sample_t [W-1:0]           data_out_q, data_out_d;
  sample_t [W-1:0]           win;
  sample_t                   left_pad, right_pad;

  logic slot_free;
  logic in_rdy;
  logic accept;
  logic emit;

  assign slot_free = !out_vld_q || bus.out_rdy;
  assign accept    = bus.in_vld && in_rdy;

  // State register (control only; sample/data registers are left unreset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cntr_q      <= '0;
      out_vld_q   <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntr_q      <= cntr_d;
      out_vld_q   <= out_vld_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_q     <= prev_d;
    cur_q      <= cur_d;
    data_out_q <= data_out_d;
  end

  // Next-state logic; cntr holds the index of the next input beat to accept
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRIME;
          cntr_d  = cntr_q + 1'b1;
        end
      end
      PRIME: begin
        if (accept) begin
          state_d = SHORT_IMG ? DRAIN : RUN;
          cntr_d  = cntr_q + 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          cntr_d = cntr_q + 1'b1;
          if (cntr_q == CNTR_LAST) state_d = DRAIN;
        end
      end
      default: begin
        if (slot_free) state_d = IDLE;
      end
    endcase
  end

  // Output decode: IDLE never emits, so it may accept even with a full slot
  always_comb begin
    in_rdy = 1'b0;
    emit   = 1'b0;
    case (state_q)
      IDLE:    in_rdy = 1'b1;
      PRIME,
      RUN: begin
        in_rdy = slot_free;
        emit   = bus.in_vld && slot_free;
      end
      default: emit = slot_free;
    endcase
  end

  assign left_pad  = (PAD_MODE == 1) ? cur_q[0]   : '0;
  assign right_pad = (PAD_MODE == 1) ? cur_q[T-1] : '0;

  // Window = tail H of previous beat, current beat, head H of the incoming beat
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_win
      if (gi < H) begin : g_left
        assign win[gi] = (state_q == PRIME) ? left_pad : prev_q[T-H+gi];
      end else if (gi < H + T) begin : g_mid
        assign win[gi] = cur_q[gi-H];
      end else begin : g_right
        assign win[gi] = (state_q == DRAIN) ? right_pad : bus.data_in[gi-H-T];
      end
    end
  endgenerate

  always_comb begin
    prev_d      = prev_q;
    cur_d       = cur_q;
    data_out_d  = data_out_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_vld_d   = out_vld_q;
    if (accept) begin
      prev_d = cur_q;
      cur_d  = bus.data_in;
    end
    if (emit) begin
      data_out_d  = win;
      out_first_d = (state_q == PRIME);
      out_last_d  = (state_q == DRAIN);
      out_vld_d   = 1'b1;
    end else if (bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.out_vld   = out_vld_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_windower_kernel.sv
// Directed bench for windower_kernel: four instances cover zero/replicate padding,
// the two-beat image (T=2,K=5) and a 1024-beat image under random backpressure.
module tb_windower_kernel;
  localparam int NC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  windower_kernel_if #(.NO_CH(NC), .THROUGHPUT(1), .KERNEL(3)) a_if ();
  windower_kernel_if #(.NO_CH(NC), .THROUGHPUT(1), .KERNEL(3)) b_if ();
  windower_kernel_if #(.NO_CH(NC), .THROUGHPUT(2), .KERNEL(5)) c_if ();
  windower_kernel_if #(.NO_CH(NC), .THROUGHPUT(1), .KERNEL(3)) d_if ();

  windower_kernel #(.NO_CH(NC), .LOG2_IMG_BEATS(2), .THROUGHPUT(1), .KERNEL(3), .PAD_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  windower_kernel #(.NO_CH(NC), .LOG2_IMG_BEATS(2), .THROUGHPUT(1), .KERNEL(3), .PAD_MODE(1))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));
  windower_kernel #(.NO_CH(NC), .LOG2_IMG_BEATS(1), .THROUGHPUT(2), .KERNEL(5), .PAD_MODE(0))
    dut_c (.clk(clk), .rst(rst), .bus(c_if));
  windower_kernel #(.NO_CH(NC), .LOG2_IMG_BEATS(10), .THROUGHPUT(1), .KERNEL(3), .PAD_MODE(0))
    dut_d (.clk(clk), .rst(rst), .bus(d_if));

  // The replicate-pad instance sees exactly the zero-pad instance's stimulus
  assign b_if.in_vld  = a_if.in_vld;
  assign b_if.data_in = a_if.data_in;
  assign b_if.out_rdy = a_if.out_rdy;

  function automatic logic [NC-1:0] smp(int k);
    return NC'(k * 37 + 11);
  endfunction

  task automatic test_reset();
    a_if.in_vld = 1'b0; a_if.data_in = '0; a_if.out_rdy = 1'b1;
    c_if.in_vld = 1'b0; c_if.data_in = '0; c_if.out_rdy = 1'b1;
    d_if.in_vld = 1'b0; d_if.data_in = '0; d_if.out_rdy = 1'b1;
    #1 rst = 1'b0;
    #1;
    checks++; if (a_if.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld_a got %b want 0", a_if.out_vld); end
    checks++; if (a_if.out_first !== 1'b0) begin errors++; $display("FAIL reset_out_first_a got %b want 0", a_if.out_first); end
    checks++; if (a_if.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last_a got %b want 0", a_if.out_last); end
    checks++; if (a_if.in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy_a got %b want 1", a_if.in_rdy); end
    checks++; if (b_if.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld_b got %b want 0", b_if.out_vld); end
    checks++; if (c_if.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld_c got %b want 0", c_if.out_vld); end
    checks++; if (d_if.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld_d got %b want 0", d_if.out_vld); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int exp_a [4][3] = '{'{0, 1, 2}, '{1, 2, 3}, '{2, 3, 4}, '{3, 4, 0}};
    int exp_b [4][3] = '{'{1, 1, 2}, '{1, 2, 3}, '{2, 3, 4}, '{3, 4, 4}};
    logic [3*NC-1:0] ev_a, ev_b;
    int beat = 0;
    int oa = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    for (int cyc = 0; cyc < 30 && oa < 4; cyc++) begin
      @(negedge clk);
      a_if.in_vld  = (beat < 4);
      a_if.data_in = NC'(beat + 1);
      a_if.out_rdy = 1'b1;
      #1;
      if (cyc == 4) begin
        checks++; if (a_if.in_rdy !== 1'b0) begin errors++; $display("FAIL basic_drain_in_rdy got %b want 0", a_if.in_rdy); end
      end
      if (a_if.out_vld === 1'b1) begin
        if (oa == 0) first_cyc = cyc;
        if (oa == 3) last_cyc = cyc;
        for (int i = 0; i < 3; i++) begin
          ev_a[i*NC +: NC] = NC'(exp_a[oa][i]);
          ev_b[i*NC +: NC] = NC'(exp_b[oa][i]);
        end
        checks++; if (a_if.data_out !== ev_a) begin errors++; $display("FAIL basic_win_zero[%0d] got %h want %h", oa, a_if.data_out, ev_a); end
        checks++; if (b_if.out_vld !== 1'b1 || b_if.data_out !== ev_b) begin errors++; $display("FAIL basic_win_repl[%0d] got vld=%b %h want vld=1 %h", oa, b_if.out_vld, b_if.data_out, ev_b); end
        checks++; if (a_if.out_first !== (oa == 0)) begin errors++; $display("FAIL basic_first[%0d] got %b want %b", oa, a_if.out_first, (oa == 0)); end
        checks++; if (a_if.out_last !== (oa == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", oa, a_if.out_last, (oa == 3)); end
        oa++;
      end
      if (a_if.in_vld && a_if.in_rdy) beat++;
    end
    checks++; if (oa != 4) begin errors++; $display("FAIL basic_count got %0d want 4", oa); end
    checks++; if (first_cyc != 2) begin errors++; $display("FAIL basic_latency_first got cycle %0d want 2", first_cyc); end
    checks++; if (last_cyc != 5) begin errors++; $display("FAIL basic_latency_last got cycle %0d want 5", last_cyc); end
    @(negedge clk);
    a_if.in_vld = 1'b0;
    #1;
    checks++; if (a_if.out_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_drop got %b want 0", a_if.out_vld); end
  endtask

  task automatic test_short_image();
    int exp_c [2][6] = '{'{0, 0, 1, 2, 3, 4}, '{1, 2, 3, 4, 0, 0}};
    logic [6*NC-1:0] ev;
    int beat = 0;
    int oc = 0;
    for (int cyc = 0; cyc < 20 && oc < 2; cyc++) begin
      @(negedge clk);
      c_if.in_vld  = (beat < 2);
      c_if.data_in = {NC'(beat * 2 + 2), NC'(beat * 2 + 1)};
      c_if.out_rdy = 1'b1;
      #1;
      if (cyc == 2) begin
        checks++; if (c_if.in_rdy !== 1'b0) begin errors++; $display("FAIL short_drain_in_rdy got %b want 0", c_if.in_rdy); end
      end
      if (c_if.out_vld === 1'b1) begin
        for (int i = 0; i < 6; i++) ev[i*NC +: NC] = NC'(exp_c[oc][i]);
        checks++; if (c_if.data_out !== ev) begin errors++; $display("FAIL short_win[%0d] got %h want %h", oc, c_if.data_out, ev); end
        checks++; if (c_if.out_first !== (oc == 0) || c_if.out_last !== (oc == 1)) begin errors++; $display("FAIL short_flags[%0d] got first=%b last=%b want first=%b last=%b", oc, c_if.out_first, c_if.out_last, (oc == 0), (oc == 1)); end
        oc++;
      end
      if (c_if.in_vld && c_if.in_rdy) beat++;
    end
    c_if.in_vld = 1'b0;
    checks++; if (oc != 2) begin errors++; $display("FAIL short_count got %0d want 2", oc); end
  endtask

  task automatic test_back_to_back();
    int exp_w [8][3] = '{'{0, 1, 2}, '{1, 2, 3}, '{2, 3, 4}, '{3, 4, 0},
                         '{0, 5, 6}, '{5, 6, 7}, '{6, 7, 8}, '{7, 8, 0}};
    logic [3*NC-1:0] ev;
    int beat = 0;
    int oa = 0;
    int stalls = 0;
    int img2_cyc = -1;
    for (int cyc = 0; cyc < 40 && oa < 8; cyc++) begin
      @(negedge clk);
      a_if.in_vld  = (beat < 8);
      a_if.data_in = NC'(beat + 1);
      a_if.out_rdy = 1'b1;
      #1;
      if (a_if.in_rdy !== 1'b1) stalls++;
      if (a_if.out_vld === 1'b1) begin
        for (int i = 0; i < 3; i++) ev[i*NC +: NC] = NC'(exp_w[oa][i]);
        checks++; if (a_if.data_out !== ev) begin errors++; $display("FAIL b2b_win[%0d] got %h want %h", oa, a_if.data_out, ev); end
        checks++; if (a_if.out_first !== (oa % 4 == 0) || a_if.out_last !== (oa % 4 == 3)) begin errors++; $display("FAIL b2b_flags[%0d] got first=%b last=%b", oa, a_if.out_first, a_if.out_last); end
        oa++;
      end
      if (a_if.in_vld && a_if.in_rdy) begin
        if (beat == 4) img2_cyc = cyc;
        beat++;
      end
    end
    a_if.in_vld = 1'b0;
    checks++; if (oa != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", oa); end
    checks++; if (stalls != 2) begin errors++; $display("FAIL b2b_bubbles got %0d want 2", stalls); end
    checks++; if (img2_cyc != 5) begin errors++; $display("FAIL b2b_img2_start got cycle %0d want 5", img2_cyc); end
  endtask

  task automatic test_reset_mid();
    int exp_w [4][3] = '{'{0, 9, 10}, '{9, 10, 11}, '{10, 11, 12}, '{11, 12, 0}};
    logic [3*NC-1:0] ev;
    int beat = 0;
    int oa = 0;
    for (int cyc = 0; cyc < 30 && beat < 6; cyc++) begin
      @(negedge clk);
      a_if.in_vld  = 1'b1;
      a_if.data_in = NC'(beat % 4 + 1);
      a_if.out_rdy = 1'b1;
      #1;
      if (a_if.in_vld && a_if.in_rdy) beat++;
    end
    @(negedge clk);
    a_if.in_vld  = 1'b0;
    a_if.out_rdy = 1'b0;
    #1;
    checks++; if (a_if.out_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre_vld got %b want 1", a_if.out_vld); end
    #1 rst = 1'b0;
    #1;
    checks++; if (a_if.out_vld !== 1'b0) begin errors++; $display("FAIL rmid_out_vld got %b want 0", a_if.out_vld); end
    checks++; if (a_if.out_first !== 1'b0) begin errors++; $display("FAIL rmid_out_first got %b want 0", a_if.out_first); end
    @(negedge clk);
    rst = 1'b1;
    a_if.out_rdy = 1'b1;
    beat = 0;
    for (int cyc = 0; cyc < 30 && oa < 4; cyc++) begin
      @(negedge clk);
      a_if.in_vld  = (beat < 4);
      a_if.data_in = NC'(beat + 9);
      a_if.out_rdy = 1'b1;
      #1;
      if (a_if.out_vld === 1'b1) begin
        for (int i = 0; i < 3; i++) ev[i*NC +: NC] = NC'(exp_w[oa][i]);
        checks++; if (a_if.data_out !== ev) begin errors++; $display("FAIL rmid_win[%0d] got %h want %h", oa, a_if.data_out, ev); end
        checks++; if (a_if.out_first !== (oa == 0) || a_if.out_last !== (oa == 3)) begin errors++; $display("FAIL rmid_flags[%0d] got first=%b last=%b", oa, a_if.out_first, a_if.out_last); end
        oa++;
      end
      if (a_if.in_vld && a_if.in_rdy) beat++;
    end
    a_if.in_vld = 1'b0;
    checks++; if (oa != 4) begin errors++; $display("FAIL rmid_count got %0d want 4", oa); end
  endtask

  task automatic test_backpressure();
    logic [3*NC-1:0] ev, held;
    int beat = 0;
    int od = 0;
    bit stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 20000 && od < 1024; cyc++) begin
      @(negedge clk);
      d_if.in_vld  = (beat < 1024) && ($urandom_range(0, 3) != 0);
      d_if.data_in = smp(beat);
      d_if.out_rdy = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        checks++; if (d_if.out_vld !== 1'b1 || d_if.data_out !== held) begin errors++; $display("FAIL bp_stable[%0d] got vld=%b %h want vld=1 %h", od, d_if.out_vld, d_if.data_out, held); end
      end
      if (d_if.out_vld === 1'b1 && d_if.out_rdy === 1'b0 && beat > 0 && beat < 1024) begin
        checks++; if (d_if.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_full[%0d] got %b want 0", beat, d_if.in_rdy); end
      end
      if (d_if.out_vld === 1'b1) begin
        ev[0 +: NC]    = (od == 0) ? '0 : smp(od - 1);
        ev[NC +: NC]   = smp(od);
        ev[2*NC +: NC] = (od == 1023) ? '0 : smp(od + 1);
        checks++; if (d_if.data_out !== ev) begin errors++; $display("FAIL bp_win[%0d] got %h want %h", od, d_if.data_out, ev); end
        checks++; if (d_if.out_first !== (od == 0) || d_if.out_last !== (od == 1023)) begin errors++; $display("FAIL bp_flags[%0d] got first=%b last=%b", od, d_if.out_first, d_if.out_last); end
        if (d_if.out_rdy) od++;
      end
      stalled = d_if.out_vld && !d_if.out_rdy;
      held    = d_if.data_out;
      if (d_if.in_vld && d_if.in_rdy) beat++;
    end
    d_if.in_vld  = 1'b0;
    d_if.out_rdy = 1'b1;
    checks++; if (od != 1024) begin errors++; $display("FAIL bp_count got %0d want 1024", od); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_image();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
